// File: rtl/ram_seq_pkg.sv
// ram_seq_pkg: shared types for the RAM sequencing initiator.
// Holds the FSM state encoding and the op field encoding; no ports.
package ram_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DUMP = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam logic OP_DUMP = 1'b0;
   localparam logic OP_FILL = 1'b1;

endpackage

// File: rtl/ram_seq_master_if.sv
// ram_seq_master_if: RAM bus plus read-stream handshake.
// master: drives mem_addr/mem_load/mem_wdata and rd_valid/rd_data,
//         receives mem_rdata (combinational from mem_addr) and rd_ready.
// slave:  the RAM and the stream consumer side.
interface ram_seq_master_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_load;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_ready;

   modport master (
      output mem_addr,
      output mem_load,
      output mem_wdata,
      input  mem_rdata,
      output rd_valid,
      output rd_data,
      input  rd_ready
   );

   modport slave (
      input  mem_addr,
      input  mem_load,
      input  mem_wdata,
      output mem_rdata,
      input  rd_valid,
      input  rd_data,
      output rd_ready
   );
endinterface

// File: rtl/ram_seq_addr_gen.sv
// ram_seq_addr_gen: address/remaining-count tracker for ram_seq_master.
// Ports: clk, rst_n; load (take base/count), step (advance one word),
// base, count (saturated to 2^ADDR_W), addr (registered, wraps),
// last (one word remaining), empty (no words remaining).
module ram_seq_addr_gen #(
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W:0]   count,
   output logic [ADDR_W-1:0] addr,
   output logic              last,
   output logic              empty
);
   localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W:0] remain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr   <= '0;
         remain <= '0;
      end else if (load) begin
         addr   <= base;
         remain <= (count > CAP) ? CAP : count;
      end else if (step) begin
         // natural ADDR_W-bit overflow gives the wrap past the top
         addr   <= addr + ADDR_W'(1);
         remain <= remain - (ADDR_W+1)'(1);
      end
   end

   assign last  = (remain == (ADDR_W+1)'(1));
   assign empty = (remain == '0);

endmodule

// File: rtl/ram_seq_master.sv
// ram_seq_master: fills a RAM range with one value or dumps a range
// over a valid/ready stream. Ports: clk, rst_n, start, op, base,
// count, fill_val, busy, done, bus (ram_seq_master_if.master), and
// checksum when RAM_SEQ_CHECKSUM_EN is defined.
module ram_seq_master
   import ram_seq_pkg::*;
#(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              op,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W:0]   count,
   input  logic [DATA_W-1:0] fill_val,
   output logic              busy,
   output logic              done,
`ifdef RAM_SEQ_CHECKSUM_EN
   output logic [DATA_W-1:0] checksum,
`endif
   ram_seq_master_if.master  bus
);

   state_t state, state_d;

   logic              ag_load;
   logic              ag_step;
   logic              ag_last;
   logic              ag_empty;
   logic [ADDR_W-1:0] ag_addr;

   logic [DATA_W-1:0] val_q;
   logic [DATA_W-1:0] data_q;
   logic              load_q, load_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic              busy_q;
   logic              accept;
   logic              capture;
   logic              hs;

   ram_seq_addr_gen #(
      .ADDR_W(ADDR_W)
   ) u_addr_gen (
      .clk  (clk),
      .rst_n(rst_n),
      .load (ag_load),
      .step (ag_step),
      .base (base),
      .count(count),
      .addr (ag_addr),
      .last (ag_last),
      .empty(ag_empty)
   );

   always_comb begin
      state_d = state;
      accept  = 1'b0;
      ag_load = 1'b0;
      ag_step = 1'b0;
      capture = 1'b0;
      load_d  = 1'b0;
      done_d  = 1'b0;
      valid_d = valid_q;
      hs      = valid_q & bus.rd_ready;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               ag_load = 1'b1;
               if (count == '0) begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end else if (op == OP_FILL) begin
                  state_d = FILL;
                  load_d  = 1'b1;
               end else begin
                  state_d = DUMP;
               end
            end
         end
         FILL: begin
            if (ag_last) begin
               state_d = FIN;
               done_d  = 1'b1;
            end else begin
               ag_step = 1'b1;
               load_d  = 1'b1;
            end
         end
         DUMP: begin
            // output register refills whenever it is empty or draining
            capture = !ag_empty && (!valid_q || bus.rd_ready);
            if (capture) begin
               ag_step = 1'b1;
               valid_d = 1'b1;
            end else if (hs) begin
               valid_d = 1'b0;
            end
            if (ag_empty && hs) begin
               state_d = FIN;
               done_d  = 1'b1;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q   <= '0;
         data_q  <= '0;
         load_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         load_q  <= load_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         busy_q  <= (state_d != IDLE);
         if (accept) begin
            val_q <= fill_val;
         end
         if (capture) begin
            data_q <= bus.mem_rdata;
         end
      end
   end

`ifdef RAM_SEQ_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q;

   // load_q marks exactly the FILL write cycles; hs only occurs in DUMP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else if (accept) begin
         sum_q <= '0;
      end else if (load_q) begin
         sum_q <= sum_q + val_q;
      end else if (hs) begin
         sum_q <= sum_q + data_q;
      end
   end

   assign checksum = sum_q;
`endif

   assign bus.mem_addr  = ag_addr;
   assign bus.mem_load  = load_q;
   assign bus.mem_wdata = val_q;
   assign bus.rd_valid  = valid_q;
   assign bus.rd_data   = data_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_ram_seq_master.sv
// tb_ram_seq_master: self-checking bench for ram_seq_master with a
// RAM model and an array-based reference of the expected contents.
module tb_ram_seq_master;
   import ram_seq_pkg::*;

   localparam int AW    = 3;
   localparam int DW    = 16;
   localparam int DEPTH = 8;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          start    = 1'b0;
   logic          op       = 1'b0;
   logic [AW-1:0] base     = '0;
   logic [AW:0]   count    = '0;
   logic [DW-1:0] fill_val = '0;
   logic          rd_ready = 1'b1;
   logic          busy;
   logic          done;
`ifdef RAM_SEQ_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   int errors = 0;
   int checks = 0;

   ram_seq_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   ram_seq_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .base    (base),
      .count   (count),
      .fill_val(fill_val),
      .busy    (busy),
      .done    (done),
`ifdef RAM_SEQ_CHECKSUM_EN
      .checksum(checksum),
`endif
      .bus     (bus)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] ram     [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];
   logic          pre_we   = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [DW-1:0] pre_data = '0;

   always @(posedge clk) begin
      if (bus.mem_load) ram[bus.mem_addr] <= bus.mem_wdata;
      else if (pre_we) ram[pre_addr] <= pre_data;
   end

   assign bus.mem_rdata = ram[bus.mem_addr];
   assign bus.rd_ready  = rd_ready;

   int            wr_addr_q [$];
   logic [DW-1:0] wr_data_q [$];
   int            wr_cyc_q  [$];
   logic [DW-1:0] rd_q      [$];
   int            rd_cyc_q  [$];
   int            done_cyc;
   bit            unstable;
   bit            busy_drop;
   logic          done_after;
   logic          busy_after;

   task automatic preload(input int a, input logic [DW-1:0] d);
      pre_we   = 1'b1;
      pre_addr = AW'(a);
      pre_data = d;
      ref_mem[a] = d;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   // issue one op and record what the DUT does, cycle by cycle
   task automatic run_op(input logic o, input logic [AW-1:0] b,
                         input logic [AW:0] c, input logic [DW-1:0] v,
                         input logic [63:0] stall, input int restart_cyc);
      logic          pv, pr;
      logic [DW-1:0] pd;
      wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
      rd_q.delete(); rd_cyc_q.delete();
      done_cyc = -1; unstable = 0; busy_drop = 0;
      start = 1'b1; op = o; base = b; count = c; fill_val = v;
      rd_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      op = 1'($urandom); base = AW'($urandom);
      count = (AW+1)'($urandom); fill_val = DW'($urandom);
      pv = 1'b0; pr = 1'b1; pd = '0;
      for (int cyc = 1; cyc < 60; cyc++) begin
         rd_ready = !stall[cyc];
         start = (cyc == restart_cyc);
         if (pv && !pr && (!bus.rd_valid || bus.rd_data !== pd)) unstable = 1;
         if (!busy) busy_drop = 1;
         if (bus.mem_load) begin
            wr_addr_q.push_back(int'(bus.mem_addr));
            wr_data_q.push_back(bus.mem_wdata);
            wr_cyc_q.push_back(cyc);
         end
         if (bus.rd_valid && rd_ready) begin
            rd_q.push_back(bus.rd_data);
            rd_cyc_q.push_back(cyc);
         end
         pv = bus.rd_valid; pr = rd_ready; pd = bus.rd_data;
         if (done) begin
            done_cyc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      rd_ready = 1'b1;
      @(posedge clk); #1;
      done_after = done;
      busy_after = busy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, bus.mem_load, bus.rd_valid, bus.mem_addr,
           bus.mem_wdata, bus.rd_data} !== '0)
         begin errors++; $display("FAIL reset_outs: got %b %b %b %b %h %h %h want all 0",
            busy, done, bus.mem_load, bus.rd_valid, bus.mem_addr, bus.mem_wdata, bus.rd_data); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({busy, done, bus.mem_load} !== 3'b000)
         begin errors++; $display("FAIL reset_idle: got %b%b%b want 000", busy, done, bus.mem_load); end
   endtask

   task automatic test_fill_dump();
      bit bad;
      run_op(OP_FILL, 3'd2, 4'd4, 16'hABCD, 64'd0, 0);
      for (int i = 0; i < 4; i++) ref_mem[2+i] = 16'hABCD;
      bad = (wr_addr_q.size() != 4);
      for (int i = 0; i < wr_addr_q.size() && i < 4; i++)
         if (wr_addr_q[i] != 2+i || wr_data_q[i] !== 16'hABCD || wr_cyc_q[i] != i+1) bad = 1;
      checks++;
      if (bad) begin errors++; $display("FAIL fill_writes: got %0d writes want 4 at 2..5 cycles 1..4", wr_addr_q.size()); end
      checks++;
      if (done_cyc != 5) begin errors++; $display("FAIL fill_done: got %0d want 5", done_cyc); end
      checks++;
      if (busy_after !== 1'b0 || done_after !== 1'b0 || busy_drop)
         begin errors++; $display("FAIL fill_busy: got after=%b drop=%b want 0/0", busy_after, busy_drop); end
      run_op(OP_DUMP, 3'd2, 4'd4, 16'h0, 64'd0, 0);
      bad = (rd_q.size() != 4) || (wr_addr_q.size() != 0);
      for (int i = 0; i < rd_q.size() && i < 4; i++)
         if (rd_q[i] !== 16'hABCD || rd_cyc_q[i] != i+2) bad = 1;
      checks++;
      if (bad) begin errors++; $display("FAIL dump_words: got %0d words want 4 x ABCD in cycles 2..5", rd_q.size()); end
      checks++;
      if (done_cyc != 6) begin errors++; $display("FAIL dump_done: got %0d want 6", done_cyc); end
   endtask

   task automatic test_wrap();
      int exp_a [4] = '{6, 7, 0, 1};
      bit bad;
      run_op(OP_FILL, 3'd6, 4'd4, 16'h1234, 64'd0, 0);
      for (int i = 0; i < 4; i++) ref_mem[exp_a[i]] = 16'h1234;
      bad = (wr_addr_q.size() != 4);
      for (int i = 0; i < wr_addr_q.size() && i < 4; i++)
         if (wr_addr_q[i] != exp_a[i] || wr_data_q[i] !== 16'h1234) bad = 1;
      checks++;
      if (bad) begin errors++; $display("FAIL wrap_addrs: got %0d writes want 6,7,0,1", wr_addr_q.size()); end
      run_op(OP_DUMP, 3'd6, 4'd4, 16'h0, 64'd0, 0);
      bad = (rd_q.size() != 4);
      for (int i = 0; i < rd_q.size() && i < 4; i++)
         if (rd_q[i] !== 16'h1234) bad = 1;
      checks++;
      if (bad) begin errors++; $display("FAIL wrap_dump: got %0d words want 4 x 1234", rd_q.size()); end
      checks++;
      if (done_cyc != 6) begin errors++; $display("FAIL wrap_done: got %0d want 6", done_cyc); end
   endtask

   task automatic test_stall();
      bit bad;
      preload(0, 16'd10);
      preload(1, 16'd20);
      preload(2, 16'd30);
      run_op(OP_DUMP, 3'd0, 4'd3, 16'h0, 64'b11100, 0);
      bad = (rd_q.size() != 3);
      if (!bad) bad = rd_q[0] !== 16'd10 || rd_q[1] !== 16'd20 || rd_q[2] !== 16'd30
                   || rd_cyc_q[0] != 5 || rd_cyc_q[2] != 7;
      checks++;
      if (bad) begin errors++; $display("FAIL stall_stream: got %0d words want 10,20,30 in cycles 5..7", rd_q.size()); end
      checks++;
      if (unstable) begin errors++; $display("FAIL stall_hold: got rd_data/rd_valid changed while stalled want stable"); end
      checks++;
      if (done_cyc != 8) begin errors++; $display("FAIL stall_done: got %0d want 8", done_cyc); end
   endtask

   task automatic test_count_edges();
      bit bad;
      run_op(OP_FILL, 3'd5, 4'd0, 16'hBEEF, 64'd0, 0);
      checks++;
      if (done_cyc != 1 || wr_addr_q.size() != 0 || busy_after !== 1'b0)
         begin errors++; $display("FAIL count0: got done=%0d writes=%0d want 1/0", done_cyc, wr_addr_q.size()); end
      run_op(OP_FILL, 3'd3, 4'd15, 16'h0F0F, 64'd0, 0);
      bad = (wr_addr_q.size() != 8);
      for (int i = 0; i < 8; i++) begin
         ref_mem[(3+i)%DEPTH] = 16'h0F0F;
         if (i < wr_addr_q.size() && wr_addr_q[i] != (3+i)%DEPTH) bad = 1;
      end
      checks++;
      if (bad || done_cyc != 9)
         begin errors++; $display("FAIL count15_fill: got %0d writes done=%0d want 8/9", wr_addr_q.size(), done_cyc); end
      preload(6, 16'h6666);
      run_op(OP_DUMP, 3'd5, 4'd15, 16'h0, 64'd0, 0);
      bad = (rd_q.size() != 8);
      for (int i = 0; i < rd_q.size() && i < 8; i++)
         if (rd_q[i] !== ref_mem[(5+i)%DEPTH]) bad = 1;
      checks++;
      if (bad || done_cyc != 10)
         begin errors++; $display("FAIL count15_dump: got %0d words done=%0d want 8/10", rd_q.size(), done_cyc); end
   endtask

   task automatic test_busy_start();
      run_op(OP_FILL, 3'd1, 4'd5, 16'h7777, 64'd0, 3);
      for (int i = 0; i < 5; i++) ref_mem[1+i] = 16'h7777;
      checks++;
      if (wr_addr_q.size() != 5 || done_cyc != 6 || busy_after !== 1'b0)
         begin errors++; $display("FAIL busy_start: got writes=%0d done=%0d busy=%b want 5/6/0",
            wr_addr_q.size(), done_cyc, busy_after); end
      run_op(OP_FILL, 3'd0, 4'd2, 16'h2222, 64'd0, 3);
      ref_mem[0] = 16'h2222; ref_mem[1] = 16'h2222;
      checks++;
      if (done_cyc != 3 || busy_after !== 1'b0)
         begin errors++; $display("FAIL fin_start: got done=%0d busy=%b want 3/0", done_cyc, busy_after); end
   endtask

`ifdef RAM_SEQ_CHECKSUM_EN
   task automatic test_checksum();
      preload(4, 16'hFFFF);
      preload(5, 16'h0002);
      run_op(OP_DUMP, 3'd4, 4'd2, 16'h0, 64'd0, 0);
      checks++;
      if (checksum !== 16'h0001) begin errors++; $display("FAIL checksum: got %h want 0001", checksum); end
   endtask
`endif

   task automatic test_reset_mid();
      logic [AW-1:0] b;
      logic [DW-1:0] v;
      bit            saw_done, bad;
      b = AW'($urandom);
      v = 16'h5A00 | DW'($urandom_range(1, 255));
      start = 1'b1; op = OP_FILL; base = b; count = 4'd8; fill_val = v;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.mem_load !== 1'b1) begin errors++; $display("FAIL rst_pre: got mem_load=%b want 1", bus.mem_load); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, bus.mem_load, bus.rd_valid, bus.mem_addr,
           bus.mem_wdata, bus.rd_data} !== '0)
         begin errors++; $display("FAIL rst_mid_outs: got %b %b %b %h %h want all 0",
            busy, done, bus.mem_load, bus.mem_addr, bus.mem_wdata); end
      ref_mem[b] = v;
      saw_done = 0;
      repeat (3) begin @(posedge clk); #1; if (done) saw_done = 1; end
      rst_n = 1'b1;
      repeat (3) begin @(posedge clk); #1; if (done || busy) saw_done = 1; end
      checks++;
      if (saw_done) begin errors++; $display("FAIL rst_mid_idle: got done/busy after abort want 0"); end
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) bad = 1;
      checks++;
      if (bad) begin errors++; $display("FAIL rst_mid_mem: got RAM differs want only addr %0d written", b); end
   endtask

   task automatic test_back_to_back();
      logic          o;
      logic [AW-1:0] b;
      logic [AW:0]   c;
      logic [DW-1:0] v, e, exp_sum;
      logic [63:0]   stall;
      int            n, exp_done;
      bit            bad;
      for (int k = 0; k < 24; k++) begin
         o = 1'($urandom);
         b = AW'($urandom);
         v = DW'($urandom);
         c = (k % 6 == 0) ? '0 : (AW+1)'($urandom_range(1, 15));
         stall = (k % 2 == 1) ? ({$urandom, $urandom} & {$urandom, $urandom}) : 64'd0;
         n = (int'(c) > DEPTH) ? DEPTH : int'(c);
         run_op(o, b, c, v, stall, 0);
         exp_sum = '0;
         bad = 0;
         if (o == OP_FILL) begin
            bad = (wr_addr_q.size() != n) || (rd_q.size() != 0);
            for (int i = 0; i < n; i++) begin
               ref_mem[(int'(b)+i)%DEPTH] = v;
               exp_sum = exp_sum + v;
               if (i < wr_addr_q.size() && (wr_addr_q[i] != (int'(b)+i)%DEPTH
                   || wr_data_q[i] !== v || wr_cyc_q[i] != i+1)) bad = 1;
            end
            exp_done = n + 1;
         end else begin
            bad = (rd_q.size() != n) || (wr_addr_q.size() != 0) || unstable;
            for (int i = 0; i < n; i++) begin
               e = ref_mem[(int'(b)+i)%DEPTH];
               exp_sum = exp_sum + e;
               if (i < rd_q.size() && rd_q[i] !== e) bad = 1;
            end
            if (n == 0) exp_done = 1;
            else if (stall == 64'd0) exp_done = n + 2;
            else if (rd_cyc_q.size() > 0) exp_done = rd_cyc_q[rd_cyc_q.size()-1] + 1;
            else exp_done = -2;
         end
         checks++;
         if (bad) begin errors++; $display("FAIL b2b_data[%0d]: got w=%0d r=%0d want %0d words op=%b",
            k, wr_addr_q.size(), rd_q.size(), n, o); end
         checks++;
         if (done_cyc != exp_done) begin errors++; $display("FAIL b2b_done[%0d]: got %0d want %0d", k, done_cyc, exp_done); end
         checks++;
         if (busy_after !== 1'b0 || done_after !== 1'b0 || busy_drop)
            begin errors++; $display("FAIL b2b_busy[%0d]: got after=%b drop=%b want 0/0", k, busy_after, busy_drop); end
         bad = 0;
         for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) bad = 1;
         checks++;
         if (bad) begin errors++; $display("FAIL b2b_mem[%0d]: got RAM differs from reference", k); end
`ifdef RAM_SEQ_CHECKSUM_EN
         checks++;
         if (checksum !== exp_sum) begin errors++; $display("FAIL b2b_sum[%0d]: got %h want %h", k, checksum, exp_sum); end
`else
         if (exp_sum === 'x) $display("note: undefined reference sum");
`endif
      end
   endtask

   initial begin
      test_reset();
      for (int i = 0; i < DEPTH; i++) preload(i, '0);
      test_fill_dump();
      test_wrap();
      test_stall();
      test_count_edges();
      test_busy_start();
`ifdef RAM_SEQ_CHECKSUM_EN
      test_checksum();
`endif
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
